gpio_in_conditioner: RTL and testbench

Input-side front end for the parity GPIO peripheral. It synchronises the 16 raw pad inputs into HCLK and debounces them as a whole word. It then presents the committed word, plus a parity bit, on the 17-bit GPIOIN bus consumed by the GPIO block. It also reports commit events and a change count for software/debug.

---
 rtl/gpio_pkg.sv | 16 +
 rtl/gpio_sync2.sv | 27 ++
 rtl/gpio_in_conditioner.sv | 124 ++++++++++++
 tb/tb_gpio_in_conditioner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: data width, debounce state encoding and the parity helper
// that is also used by the GPIO block.
package gpio_pkg;

  localparam int GPIO_DATA_W = 16;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } gpio_db_state_t;

  function automatic logic gpio_parity(input logic [GPIO_DATA_W-1:0] data, input logic sel);
    return (^data) ^ sel;
  endfunction

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchroniser bringing asynchronous pad levels into the HCLK domain.
module gpio_sync2 #(
  parameter int WIDTH = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;

  // Synchroniser stages, cleared by synchronous reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= d;
      sync2_r <= sync1_r;
    end
  end

  assign q = sync2_r;

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input front end: synchronise, whole-word debounce, parity-tagged GPIOIN bus.
// Optional macro GPIO_PARITY_INJECT_EN adds PARINJ to force a parity error.
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [GPIO_DATA_W-1:0] PADIN,
`ifdef GPIO_PARITY_INJECT_EN
  input  logic                   PARINJ,
`endif
  input  logic                   PARITYSEL,
  output logic [GPIO_DATA_W:0]   GPIOIN,
  output logic                   CHANGED,
  output logic                   STABLE,
  output logic [CNT_W-1:0]       CHGCNT
);

  localparam int CNT_BITS = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [GPIO_DATA_W-1:0] sync_s;
  gpio_db_state_t         state_r, state_s;
  logic [GPIO_DATA_W-1:0] data_r, data_s;
  logic [GPIO_DATA_W-1:0] cand_r, cand_s;
  logic [CNT_BITS-1:0]    cnt_r, cnt_s;
  logic                   changed_r, changed_s;
  logic [CNT_W-1:0]       chgcnt_r, chgcnt_s;
  logic                   par_s;

  gpio_sync2 #(.WIDTH(GPIO_DATA_W)) u_sync (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .d      (PADIN),
    .q      (sync_s)
  );

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r <= ST_STABLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath decisions; a new bounce restarts the count on the new candidate
  always_comb begin
    state_s   = state_r;
    data_s    = data_r;
    cand_s    = cand_r;
    cnt_s     = cnt_r;
    changed_s = 1'b0;
    chgcnt_s  = chgcnt_r;
    case (state_r)
      ST_STABLE: begin
        if (sync_s != data_r) begin
          cand_s  = sync_s;
          cnt_s   = CNT_ONE;
          state_s = ST_SETTLE;
        end else begin
          state_s = ST_STABLE;
        end
      end
      ST_SETTLE: begin
        if (sync_s == data_r) begin
          cnt_s   = {CNT_BITS{1'b0}};
          state_s = ST_STABLE;
        end else if (sync_s != cand_r) begin
          cand_s = sync_s;
          cnt_s  = CNT_ONE;
        end else if (cnt_r == CNT_LAST) begin
          data_s    = cand_r;
          changed_s = 1'b1;
          chgcnt_s  = chgcnt_r + CNT_W'(1);
          cnt_s     = {CNT_BITS{1'b0}};
          state_s   = ST_STABLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_s   = {CNT_BITS{1'b0}};
        state_s = ST_STABLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      data_r    <= {GPIO_DATA_W{1'b0}};
      cand_r    <= {GPIO_DATA_W{1'b0}};
      cnt_r     <= {CNT_BITS{1'b0}};
      changed_r <= 1'b0;
      chgcnt_r  <= {CNT_W{1'b0}};
    end else begin
      data_r    <= data_s;
      cand_r    <= cand_s;
      cnt_r     <= cnt_s;
      changed_r <= changed_s;
      chgcnt_r  <= chgcnt_s;
    end
  end

  // Outputs; parity follows PARITYSEL combinationally so the downstream checker sees no error
  always_comb begin
`ifdef GPIO_PARITY_INJECT_EN
    par_s = gpio_parity(data_r, PARITYSEL) ^ PARINJ;
`else
    par_s = gpio_parity(data_r, PARITYSEL);
`endif
    GPIOIN = {par_s, data_r};
    STABLE = (state_r == ST_STABLE);
  end

  assign CHANGED = changed_r;
  assign CHGCNT  = chgcnt_r;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner (DEBOUNCE_CYCLES=4, CNT_W=8).
module tb_gpio_in_conditioner;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [15:0] PADIN;
  logic        PARITYSEL;
`ifdef GPIO_PARITY_INJECT_EN
  logic        PARINJ;
`endif
  logic [16:0] GPIOIN;
  logic        CHANGED;
  logic        STABLE;
  logic [7:0]  CHGCNT;

  int total = 0;
  int bad   = 0;
  int pulses;

  gpio_in_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .PADIN     (PADIN),
`ifdef GPIO_PARITY_INJECT_EN
    .PARINJ    (PARINJ),
`endif
    .PARITYSEL (PARITYSEL),
    .GPIOIN    (GPIOIN),
    .CHANGED   (CHANGED),
    .STABLE    (STABLE),
    .CHGCNT    (CHGCNT)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET    = 1'b1;
    PADIN     = 16'hFFFF;
    PARITYSEL = 1'b0;
`ifdef GPIO_PARITY_INJECT_EN
    PARINJ    = 1'b0;
`endif
    // 1. reset
    tick();
    tick();
    check("rst_gpioin", 32'(GPIOIN), 32'h0_0000);
    check("rst_stable", 32'(STABLE), 32'd1);
    check("rst_changed", 32'(CHANGED), 32'd0);
    check("rst_chgcnt", 32'(CHGCNT), 32'd0);
    HRESET = 1'b0;
    PADIN  = 16'h0000;
    tick();
    tick();
    tick();
    check("idle_changed", 32'(CHANGED), 32'd0);

    // 2. clean change, commit at 6th edge
    PADIN = 16'h00A5;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("clean_wait_changed", 32'(CHANGED), 32'd0);
      check("clean_wait_gpioin", 32'(GPIOIN), 32'h0_0000);
    end
    tick();
    check("clean_gpioin", 32'(GPIOIN), 32'h0_00A5);
    check("clean_changed", 32'(CHANGED), 32'd1);
    check("clean_chgcnt", 32'(CHGCNT), 32'd1);
    tick();
    check("clean_changed_drop", 32'(CHANGED), 32'd0);

    // back to zero for the glitch test
    PADIN = 16'h0000;
    for (int i = 1; i <= 6; i++) tick();
    check("zero_gpioin", 32'(GPIOIN), 32'h0_0000);
    check("zero_changed", 32'(CHANGED), 32'd1);
    check("zero_chgcnt", 32'(CHGCNT), 32'd2);
    tick();

    // 3. two-cycle glitch is rejected
    PADIN = 16'h0001;
    tick();
    tick();
    PADIN = 16'h0000;
    tick();
    check("glitch_settling", 32'(STABLE), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("glitch_changed", 32'(CHANGED), 32'd0);
    end
    check("glitch_gpioin", 32'(GPIOIN), 32'h0_0000);
    check("glitch_stable", 32'(STABLE), 32'd1);
    check("glitch_chgcnt", 32'(CHGCNT), 32'd2);

    // 4. bounce then hold 0003
    PADIN = 16'h0001; tick();
    PADIN = 16'h0003; tick();
    PADIN = 16'h0001; tick();
    PADIN = 16'h0003; tick();
    PADIN = 16'h0001; tick();
    PADIN = 16'h0003;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("bounce_wait_changed", 32'(CHANGED), 32'd0);
      check("bounce_wait_gpioin", 32'(GPIOIN), 32'h0_0000);
    end
    tick();
    check("bounce_gpioin", 32'(GPIOIN), 32'h0_0003);
    check("bounce_changed", 32'(CHANGED), 32'd1);
    check("bounce_chgcnt", 32'(CHGCNT), 32'd3);
    tick();
    check("bounce_changed_drop", 32'(CHANGED), 32'd0);

    // 5. parity select
    PADIN = 16'h0007;
    for (int i = 1; i <= 6; i++) tick();
    check("par_even", 32'(GPIOIN), 32'h1_0007);
    check("par_chgcnt", 32'(CHGCNT), 32'd4);
    PARITYSEL = 1'b1;
    #1;
    check("par_odd", 32'(GPIOIN), 32'h0_0007);
`ifdef GPIO_PARITY_INJECT_EN
    PARINJ = 1'b1;
    #1;
    check("par_inject", 32'(GPIOIN), 32'h1_0007);
    PARINJ = 1'b0;
    #1;
    check("par_inject_off", 32'(GPIOIN), 32'h0_0007);
`endif
    PARITYSEL = 1'b0;
    #1;
    check("par_even_again", 32'(GPIOIN), 32'h1_0007);
    tick();

    // 6a. reset in the middle of settling
    PADIN = 16'h0000;
    for (int i = 1; i <= 4; i++) tick();
    check("midrst_settling", 32'(STABLE), 32'd0);
    HRESET = 1'b1;
    tick();
    check("midrst_gpioin", 32'(GPIOIN), 32'h0_0000);
    check("midrst_stable", 32'(STABLE), 32'd1);
    check("midrst_changed", 32'(CHANGED), 32'd0);
    check("midrst_chgcnt", 32'(CHGCNT), 32'd0);
    HRESET = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("midrst_no_commit", 32'(CHANGED), 32'd0);
    end

    // 6b. 256 commits wrap CHGCNT
    pulses = 0;
    for (int n = 0; n < 256; n++) begin
      PADIN = (n % 2 == 0) ? 16'h0001 : 16'h0000;
      for (int i = 1; i <= 7; i++) begin
        tick();
        if (CHANGED === 1'b1) pulses++;
      end
      if (n == 254) check("wrap_chgcnt_255", 32'(CHGCNT), 32'd255);
    end
    check("wrap_pulses", 32'(pulses), 32'd256);
    check("wrap_chgcnt_0", 32'(CHGCNT), 32'd0);
    check("wrap_gpioin", 32'(GPIOIN), 32'h0_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
